// File: rtl/exc_ctrl.sv
// exc_ctrl: exception sequencer that sits beside the LEGv8 PC mux.
// It takes synchronous exceptions from the decoder and level-sensitive external
// interrupts, squashes the offending instruction and redirects fetch to VECTOR.
// ERET redirects fetch back to the saved link register.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   RUN     | normal execution; any exception cause is taken immediately
//   TAKE    | one-cycle redirect to VECTOR; ExtIAck pulses for an IRQ
//   HANDLER | handler is running; IRQs are masked; a new cause is fatal
//   RETURN  | one-cycle redirect back to ELR, which ends the handler
//   HALT    | double fault; the block stays here until reset
module exc_ctrl #(
  parameter int             N      = 64,
  parameter logic [N-1:0]   VECTOR = 64'h0000_0000_0000_00D8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] PC,
  input  logic [3:0]   EStatus,
  input  logic         ERet,
  input  logic         ExtIRQ,
  output logic         Flush,
  output logic         Redirect,
  output logic [N-1:0] RedirectPC,
  output logic         ExtIAck,
  output logic         InHandler,
  output logic         DoubleFault,
  output logic [N-1:0] ELR,
  output logic [3:0]   ESR,
  output logic [7:0]   ExcCount
);

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_TAKE    = 3'd1,
    S_HANDLER = 3'd2,
    S_RETURN  = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  localparam logic [3:0] CAUSE_IRQ = 4'b0001;

  state_t state;
  logic   sync_exc;
  logic   exc;

  assign sync_exc = (EStatus != 4'b0000);
  assign exc      = sync_exc | ExtIRQ;

  // Sequencer state plus the saved link register, cause and exception count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_RUN;
      ELR      <= '0;
      ESR      <= '0;
      ExcCount <= '0;
    end else begin
      case (state)
        S_RUN: begin
          // ERET here is treated as a NOP; only an exception cause changes state
          if (exc) begin
            ELR   <= PC;
            ESR   <= sync_exc ? EStatus : CAUSE_IRQ;
            state <= S_TAKE;
            if (ExcCount != 8'hFF) ExcCount <= ExcCount + 8'd1;
          end
        end
        S_TAKE: state <= S_HANDLER;
        S_HANDLER: begin
          // A fault inside the handler wins over ERET; ELR keeps the original return point
          if (sync_exc) begin
            ESR   <= EStatus;
            state <= S_HALT;
          end else if (ERet) begin
            state <= S_RETURN;
          end
        end
        S_RETURN: begin
          ESR   <= '0;
          state <= S_RUN;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_RUN;
      endcase
    end
  end

  // Redirect, acknowledge and status outputs depend only on the registered state.
  always_comb begin
    Redirect    = 1'b0;
    RedirectPC  = '0;
    ExtIAck     = 1'b0;
    InHandler   = 1'b0;
    DoubleFault = 1'b0;
    case (state)
      S_TAKE: begin
        Redirect   = 1'b1;
        RedirectPC = VECTOR;
        ExtIAck    = (ESR == CAUSE_IRQ);
      end
      S_HANDLER: InHandler = 1'b1;
      S_RETURN: begin
        Redirect   = 1'b1;
        RedirectPC = ELR;
        InHandler  = 1'b1;
      end
      S_HALT: begin
        Redirect    = 1'b1;
        RedirectPC  = VECTOR;
        DoubleFault = 1'b1;
      end
      default: ;
    endcase
  end

  // Flush squashes the current instruction. It is held low while reset is
  // asserted, so every output reads 0 during reset.
  always_comb begin
    Flush = 1'b0;
    case (state)
      S_RUN:     Flush = exc;
      S_TAKE:    Flush = 1'b1;
      S_HANDLER: Flush = sync_exc;
      S_RETURN:  Flush = 1'b1;
      S_HALT:    Flush = 1'b1;
      default:   Flush = 1'b0;
    endcase
    if (!reset) Flush = 1'b0;
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl. Each table row lists the inputs for one cycle
// and the outputs expected during that same cycle. Hand-written sequences
// cover HALT persistence, count saturation and an asynchronous reset.
module tb_exc_ctrl;

  localparam logic [63:0] D8 = 64'hD8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] pc;
  logic [3:0]  estatus;
  logic        eret;
  logic        extirq;
  logic        flush, redirect, ext_iack, in_handler, double_fault;
  logic [63:0] redirect_pc, elr;
  logic [3:0]  esr;
  logic [7:0]  exc_count;

  int n_vec = 0;
  int n_err = 0;

  exc_ctrl dut (
    .clk(clk), .reset(reset_n), .PC(pc), .EStatus(estatus), .ERet(eret),
    .ExtIRQ(extirq), .Flush(flush), .Redirect(redirect), .RedirectPC(redirect_pc),
    .ExtIAck(ext_iack), .InHandler(in_handler), .DoubleFault(double_fault),
    .ELR(elr), .ESR(esr), .ExcCount(exc_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl, rd;
    logic [63:0] rpc;
    logic        ia, ih, df;
    logic [63:0] elr;
    logic [3:0]  esr;
    logic [7:0]  cnt;
  } exp_t;

  typedef struct {
    logic [63:0] pc;
    logic [3:0]  es;
    logic        er, irq;
    exp_t        x;
  } vec_t;

  function automatic exp_t ex(logic fl, logic rd, logic [63:0] rpc, logic ia, logic ih,
                              logic df, logic [63:0] e, logic [3:0] s, logic [7:0] c);
    exp_t r;
    r.fl = fl; r.rd = rd; r.rpc = rpc; r.ia = ia; r.ih = ih; r.df = df;
    r.elr = e; r.esr = s; r.cnt = c;
    return r;
  endfunction

  function automatic vec_t v(logic [63:0] p, logic [3:0] s, logic r, logic q, exp_t x);
    vec_t t;
    t.pc = p; t.es = s; t.er = r; t.irq = q; t.x = x;
    return t;
  endfunction

  task automatic drive(logic [63:0] p, logic [3:0] s, logic r, logic q);
    pc = p; estatus = s; eret = r; extirq = q;
  endtask

  task automatic check(string name, exp_t x);
    n_vec++;
    if (flush !== x.fl || redirect !== x.rd || redirect_pc !== x.rpc || ext_iack !== x.ia ||
        in_handler !== x.ih || double_fault !== x.df || elr !== x.elr || esr !== x.esr ||
        exc_count !== x.cnt) begin
      n_err++;
      $display("FAIL %s: got fl=%b rd=%b rpc=%h ia=%b ih=%b df=%b elr=%h esr=%h cnt=%h / want fl=%b rd=%b rpc=%h ia=%b ih=%b df=%b elr=%h esr=%h cnt=%h",
               name, flush, redirect, redirect_pc, ext_iack, in_handler, double_fault, elr, esr,
               exc_count, x.fl, x.rd, x.rpc, x.ia, x.ih, x.df, x.elr, x.esr, x.cnt);
    end
  endtask

  vec_t tbl[23];
  exp_t zero;

  initial begin
    zero = ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // idle after reset, then ERET in RUN is ignored
    for (int i = 0; i < 5; i++) tbl[i] = v(0, 0, 0, 0, zero);
    tbl[5]  = v(64'h4, 0, 1, 0, zero);
    // synchronous exception round trip
    tbl[6]  = v(64'h40, 4'h2, 0, 0, ex(1, 0, 0,     0, 0, 0, 0,     0, 0));
    tbl[7]  = v(64'h44, 0,    0, 0, ex(1, 1, D8,    0, 0, 0, 64'h40, 2, 1));
    tbl[8]  = v(64'hD8, 0,    0, 0, ex(0, 0, 0,     0, 1, 0, 64'h40, 2, 1));
    tbl[9]  = v(64'hDC, 0,    1, 0, ex(0, 0, 0,     0, 1, 0, 64'h40, 2, 1));
    tbl[10] = v(64'hE0, 0,    0, 0, ex(1, 1, 64'h40, 0, 1, 0, 64'h40, 2, 1));
    tbl[11] = v(64'h40, 0,    0, 0, ex(0, 0, 0,     0, 0, 0, 64'h40, 0, 1));
    // IRQ held for four cycles: taken once, masked in HANDLER
    tbl[12] = v(64'h100, 0, 0, 1, ex(1, 0, 0,      0, 0, 0, 64'h40,  0, 1));
    tbl[13] = v(64'h104, 0, 0, 1, ex(1, 1, D8,     1, 0, 0, 64'h100, 1, 2));
    tbl[14] = v(64'hD8,  0, 0, 1, ex(0, 0, 0,      0, 1, 0, 64'h100, 1, 2));
    tbl[15] = v(64'hDC,  0, 0, 1, ex(0, 0, 0,      0, 1, 0, 64'h100, 1, 2));
    tbl[16] = v(64'hE0,  0, 1, 0, ex(0, 0, 0,      0, 1, 0, 64'h100, 1, 2));
    tbl[17] = v(64'hE4,  0, 0, 0, ex(1, 1, 64'h100, 0, 1, 0, 64'h100, 1, 2));
    tbl[18] = v(64'h100, 0, 0, 0, ex(0, 0, 0,      0, 0, 0, 64'h100, 0, 2));
    // sync cause beats IRQ, then a double fault with ERET also present
    tbl[19] = v(64'h200, 4'h2, 0, 1, ex(1, 0, 0,  0, 0, 0, 64'h100, 0, 3'd2));
    tbl[20] = v(64'h204, 0,    0, 1, ex(1, 1, D8, 0, 0, 0, 64'h200, 2, 3));
    tbl[21] = v(64'hD8,  4'h4, 1, 0, ex(1, 0, 0,  0, 1, 0, 64'h200, 2, 3));
    tbl[22] = v(64'hDC,  0,    1, 1, ex(1, 1, D8, 0, 0, 1, 64'h200, 4, 3));

    reset_n = 1'b0;
    drive(0, 0, 0, 0);
    #2 check("reset_held", zero);
    @(negedge clk) reset_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].pc, tbl[i].es, tbl[i].er, tbl[i].irq);
      #1 check($sformatf("row%0d", i), tbl[i].x);
    end

    // HALT ignores every input until reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(64'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      #1 check($sformatf("halt%0d", i), ex(1, 1, D8, 0, 0, 1, 64'h200, 4, 3));
    end
    @(negedge clk);
    drive(0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1 check("halt_reset", zero);
    @(negedge clk) reset_n = 1'b1;

    // 256 round trips saturate the counter at FF
    for (int i = 0; i < 256; i++) begin
      @(negedge clk) drive(64'(i * 4), 4'h2, 0, 0);
      @(negedge clk) drive(0, 0, 0, 0);
      @(negedge clk) drive(0, 0, 1, 0);
      @(negedge clk) drive(0, 0, 0, 0);
      if (i == 254) begin
        @(negedge clk);
        #1 check("count_fe_boundary", ex(0, 0, 0, 0, 0, 0, 64'h3F8, 0, 8'hFF));
      end
    end
    @(negedge clk) drive(64'h400, 0, 0, 0);
    #1 check("count_saturated", ex(0, 0, 0, 0, 0, 0, 64'h3FC, 0, 8'hFF));

    // asynchronous reset in the middle of the TAKE cycle
    @(negedge clk) drive(64'h500, 4'h3, 0, 0);
    @(negedge clk) drive(0, 0, 0, 0);
    #1 check("take_before_reset", ex(1, 1, D8, 0, 0, 0, 64'h500, 3, 8'hFF));
    #1 reset_n = 1'b0;
    #1 check("take_async_reset", zero);
    @(posedge clk);
    #1 check("after_edge_in_reset", zero);
    @(negedge clk) reset_n = 1'b1;
    #1 check("reset_released", zero);
    @(negedge clk);
    #1 check("idle_after_reset", zero);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
